// File: rtl/alu_rs_pkg.sv
// Shared ALU reservation-station definitions: widths, tag encoding, opcodes,
// the entry record and the CDB operand-capture helper.
package alu_rs_pkg;

  localparam int dataWidth  = 32;
  localparam int tagWidth   = 4;
  localparam int newopWidth = 4;
  localparam int aluWidth   = 2*tagWidth + tagWidth + 2*dataWidth + newopWidth;

  localparam logic [tagWidth-1:0] tagFree = 4'b0000;

  typedef enum logic [newopWidth-1:0] {
    NOP  = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    AND  = 4'd3,
    OR   = 4'd4,
    XOR  = 4'd5,
    SLL  = 4'd6,
    SRL  = 4'd7,
    SRA  = 4'd8,
    SLT  = 4'd9,
    SLTU = 4'd10
  } newop_t;

  // Field order mirrors the dispatch bus so the bus can be cast straight into an entry.
  typedef struct packed {
    logic [tagWidth-1:0]   dest;
    logic [tagWidth-1:0]   tag2;
    logic [dataWidth-1:0]  data2;
    logic [tagWidth-1:0]   tag1;
    logic [dataWidth-1:0]  data1;
    logic [newopWidth-1:0] op;
  } rs_entry_t;

  function automatic rs_entry_t wake(input rs_entry_t e,
                                     input logic cdb_valid,
                                     input logic [tagWidth-1:0] cdb_tag,
                                     input logic [dataWidth-1:0] cdb_data);
    rs_entry_t r;
    r = e;
    if (cdb_valid && (cdb_tag != tagFree) && (e.tag1 == cdb_tag)) begin
      r.data1 = cdb_data;
      r.tag1  = tagFree;
    end else begin
      r.data1 = e.data1;
    end
    if (cdb_valid && (cdb_tag != tagFree) && (e.tag2 == cdb_tag)) begin
      r.data2 = cdb_data;
      r.tag2  = tagFree;
    end else begin
      r.data2 = e.data2;
    end
    return r;
  endfunction

  function automatic logic is_ready(input rs_entry_t e);
    return (e.tag1 == tagFree) && (e.tag2 == tagFree);
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority picker: one-hot grant, binary index and found flag.
module rs_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  assign found  = |req;
  // Two's-complement trick isolates the lowest set request bit.
  assign onehot = req & (~req + N'(1));

  // Encode the one-hot grant into a binary index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = idx | ({IW{onehot[i]}} & IW'(i));
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: in-order-free allocation, CDB operand capture and
// single-issue of the lowest-indexed ready entry with registered issue outputs.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aluEnable,
  input  logic [aluWidth-1:0]   aluData,
  output logic                  rsFull,
  input  logic                  flush,
  input  logic                  cdbValid,
  input  logic [tagWidth-1:0]   cdbTag,
  input  logic [dataWidth-1:0]  cdbData,
  output logic                  issueValid,
  output logic [newopWidth-1:0] issueOp,
  output logic [dataWidth-1:0]  issueData1,
  output logic [dataWidth-1:0]  issueData2,
  output logic [tagWidth-1:0]   issueDest
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] busy_r;
  logic [RS_DEPTH-1:0] busy_nxt_s;
  logic [RS_DEPTH-1:0] free_req_s;
  logic [RS_DEPTH-1:0] ready_s;
  logic [RS_DEPTH-1:0] free_oh_s;
  logic [RS_DEPTH-1:0] iss_oh_s;
  logic [IDX_W-1:0]    free_idx_s;
  logic [IDX_W-1:0]    iss_idx_s;
  logic                free_found_s;
  logic                iss_found_s;
  logic                alloc_s;
  rs_entry_t           new_s;
  rs_entry_t           ent_r     [RS_DEPTH];
  rs_entry_t           ent_nxt_s [RS_DEPTH];

  assign rsFull     = &busy_r;
  assign free_req_s = ~busy_r;
  assign alloc_s    = aluEnable & free_found_s;
  // An incoming op sees the same-cycle broadcast so it never misses its producer.
  assign new_s      = wake(rs_entry_t'(aluData), cdbValid, cdbTag, cdbData);

  // Per-entry readiness from pre-edge state.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_s[i] = busy_r[i] & is_ready(ent_r[i]);
    end
  end

  rs_pick #(.N(RS_DEPTH), .IW(IDX_W)) u_free_pick (
    .req    (free_req_s),
    .onehot (free_oh_s),
    .idx    (free_idx_s),
    .found  (free_found_s)
  );

  rs_pick #(.N(RS_DEPTH), .IW(IDX_W)) u_ready_pick (
    .req    (ready_s),
    .onehot (iss_oh_s),
    .idx    (iss_idx_s),
    .found  (iss_found_s)
  );

  // Next-state of the entry array: wakeup, issue release and allocation.
  always_comb begin
    busy_nxt_s = (busy_r & ~iss_oh_s) | ({RS_DEPTH{alloc_s}} & free_oh_s);
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (alloc_s && (free_idx_s == IDX_W'(i))) begin
        ent_nxt_s[i] = new_s;
      end else if (busy_r[i]) begin
        ent_nxt_s[i] = wake(ent_r[i], cdbValid, cdbTag, cdbData);
      end else begin
        ent_nxt_s[i] = ent_r[i];
      end
    end
  end

  // Entry storage; flush only drops busy bits, payloads are don't-care when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else if (flush) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_r[i] <= ent_nxt_s[i];
      end
    end
  end

  // Registered issue port; payload holds when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      issueValid <= 1'b0;
      issueOp    <= NOP;
      issueData1 <= '0;
      issueData2 <= '0;
      issueDest  <= tagFree;
    end else if (flush) begin
      issueValid <= 1'b0;
    end else if (iss_found_s) begin
      issueValid <= 1'b1;
      issueOp    <= ent_r[iss_idx_s].op;
      issueData1 <= ent_r[iss_idx_s].data1;
      issueData2 <= ent_r[iss_idx_s].data2;
      issueDest  <= ent_r[iss_idx_s].dest;
    end else begin
      issueValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed scenarios then random traffic, checked
// against a behavioural reservation-station model.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic                  aluEnable = 1'b0;
  logic [aluWidth-1:0]   aluData = '0;
  logic                  rsFull;
  logic                  flush = 1'b0;
  logic                  cdbValid = 1'b0;
  logic [tagWidth-1:0]   cdbTag = '0;
  logic [dataWidth-1:0]  cdbData = '0;
  logic                  issueValid;
  logic [newopWidth-1:0] issueOp;
  logic [dataWidth-1:0]  issueData1;
  logic [dataWidth-1:0]  issueData2;
  logic [tagWidth-1:0]   issueDest;

  alu_rs #(.RS_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .aluEnable(aluEnable), .aluData(aluData), .rsFull(rsFull),
    .flush(flush), .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .issueValid(issueValid), .issueOp(issueOp), .issueData1(issueData1),
    .issueData2(issueData2), .issueDest(issueDest)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus for the next cycle; step() applies and then clears it.
  bit s_rst, s_flush, s_en, s_cv;
  logic [3:0]  s_op, s_t1, s_t2, s_dest, s_ct;
  logic [31:0] s_d1, s_d2, s_cd;

  // Behavioural model: a table of waiting ops plus the visible issue port.
  bit          m_busy [D];
  logic [3:0]  m_op [D], m_t1 [D], m_t2 [D], m_dest [D];
  logic [31:0] m_d1 [D], m_d2 [D];
  bit          o_v;
  logic [3:0]  o_op, o_dest;
  logic [31:0] o_d1, o_d2;

  typedef struct {
    bit          v;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic [3:0]  dest;
    bit          full;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  task automatic clear_stim();
    s_rst = 0; s_flush = 0; s_en = 0; s_cv = 0;
    s_op = 4'd0; s_t1 = 4'd0; s_t2 = 4'd0; s_dest = 4'd0; s_ct = 4'd0;
    s_d1 = 32'd0; s_d2 = 32'd0; s_cd = 32'd0;
  endtask

  task automatic model_step();
    int iss;
    int fr;
    bit full;
    if (s_rst) begin
      for (int i = 0; i < D; i++) m_busy[i] = 0;
      o_v = 0; o_op = NOP; o_d1 = 32'd0; o_d2 = 32'd0; o_dest = 4'd0;
    end else if (s_flush) begin
      for (int i = 0; i < D; i++) m_busy[i] = 0;
      o_v = 0;
    end else begin
      iss = -1;
      fr = -1;
      for (int i = 0; i < D; i++) begin
        if (iss < 0 && m_busy[i] && m_t1[i] == 4'd0 && m_t2[i] == 4'd0) iss = i;
        if (fr < 0 && !m_busy[i]) fr = i;
      end
      if (iss >= 0) begin
        o_v = 1; o_op = m_op[iss]; o_d1 = m_d1[iss]; o_d2 = m_d2[iss]; o_dest = m_dest[iss];
      end else begin
        o_v = 0;
      end
      if (s_cv && s_ct != 4'd0) begin
        for (int i = 0; i < D; i++) begin
          if (m_busy[i] && m_t1[i] == s_ct) begin m_d1[i] = s_cd; m_t1[i] = 4'd0; end
          if (m_busy[i] && m_t2[i] == s_ct) begin m_d2[i] = s_cd; m_t2[i] = 4'd0; end
        end
      end
      if (iss >= 0) m_busy[iss] = 0;
      if (s_en && fr >= 0) begin
        m_busy[fr] = 1; m_op[fr] = s_op; m_dest[fr] = s_dest;
        m_t1[fr] = s_t1; m_d1[fr] = s_d1; m_t2[fr] = s_t2; m_d2[fr] = s_d2;
        if (s_cv && s_ct != 4'd0 && s_t1 == s_ct) begin m_d1[fr] = s_cd; m_t1[fr] = 4'd0; end
        if (s_cv && s_ct != 4'd0 && s_t2 == s_ct) begin m_d2[fr] = s_cd; m_t2[fr] = 4'd0; end
      end
    end
    full = 1;
    for (int i = 0; i < D; i++) if (!m_busy[i]) full = 0;
    sb.push_back('{v: o_v, op: o_op, d1: o_d1, d2: o_d2, dest: o_dest, full: full});
  endtask

  task automatic step();
    @(negedge clk);
    rst = s_rst; flush = s_flush; aluEnable = s_en;
    aluData = {s_dest, s_t2, s_d2, s_t1, s_d1, s_op};
    cdbValid = s_cv; cdbTag = s_ct; cdbData = s_cd;
    model_step();
    clear_stim();
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] t1, input logic [31:0] d1,
                      input logic [3:0] t2, input logic [31:0] d2, input logic [3:0] dest);
    s_en = 1; s_op = op; s_t1 = t1; s_d1 = d1; s_t2 = t2; s_d2 = d2; s_dest = dest;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] d);
    s_cv = 1; s_ct = t; s_cd = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Monitor: one expected record per cycle, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("issueValid", {31'd0, issueValid}, {31'd0, cur.v});
      chk("rsFull", {31'd0, rsFull}, {31'd0, cur.full});
      chk("issueOp", {28'd0, issueOp}, {28'd0, cur.op});
      chk("issueData1", issueData1, cur.d1);
      chk("issueData2", issueData2, cur.d2);
      chk("issueDest", {28'd0, issueDest}, {28'd0, cur.dest});
    end
  end

  initial begin
    clear_stim();
    s_rst = 1; step();
    s_rst = 1; step();

    // Fully ready ADD issues two edges after dispatch.
    disp(ADD, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3); step();
    step();
    @(posedge clk); #2;
    chk("d_add_valid", {31'd0, issueValid}, 32'd1);
    chk("d_add_data1", issueData1, 32'd5);
    chk("d_add_data2", issueData2, 32'd7);
    chk("d_add_dest", {28'd0, issueDest}, 32'd3);

    // SUB waits on tag 6, woken two cycles later.
    disp(SUB, 4'd6, 32'd0, 4'd0, 32'd10, 4'd2); step();
    step();
    bcast(4'd6, 32'd42); step();
    step();
    @(posedge clk); #2;
    chk("d_sub_data1", issueData1, 32'd42);
    idle(1);

    // Same-cycle dispatch and broadcast on tag2.
    disp(XOR, 4'd0, 32'h1234, 4'd9, 32'd0, 4'd4); bcast(4'd9, 32'hFFFF_FFFF); step();
    step();
    @(posedge clk); #2;
    chk("d_same_cycle_data2", issueData2, 32'hFFFF_FFFF);
    idle(1);

    // Fill all entries on tag 5, drop a ninth, then drain in index order.
    for (int i = 0; i < D; i++) begin
      disp(ADD, 4'd5, 32'd0, 4'd0, 32'(i + 100), 4'(i + 1)); step();
    end
    disp(SUB, 4'd0, 32'd1, 4'd0, 32'd1, 4'd15); step();
    @(posedge clk); #2;
    chk("d_full", {31'd0, rsFull}, 32'd1);
    bcast(4'd5, 32'd77); step();
    idle(D + 2);

    // Flush with three busy (one ready) and a simultaneous dispatch.
    disp(ADD, 4'd7, 32'd0, 4'd0, 32'd1, 4'd1); step();
    disp(ADD, 4'd7, 32'd0, 4'd0, 32'd2, 4'd2); step();
    disp(ADD, 4'd0, 32'd3, 4'd0, 32'd3, 4'd3); step();
    s_flush = 1; disp(SUB, 4'd0, 32'd9, 4'd0, 32'd9, 4'd9); step();
    bcast(4'd7, 32'd5); step();
    idle(3);

    // Reset mid-operation with four busy and a broadcast pending.
    for (int i = 0; i < 4; i++) begin
      disp(ADD, 4'd8, 32'd0, 4'd0, 32'(i), 4'(i + 1)); step();
    end
    s_rst = 1; bcast(4'd8, 32'd3); disp(ADD, 4'd0, 32'd1, 4'd0, 32'd1, 4'd1); step();
    bcast(4'd8, 32'd3); step();
    idle(3);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      s_rst = ($urandom_range(0, 199) == 0);
      s_flush = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 6) begin
        disp(4'($urandom_range(1, 10)),
             ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 5)), $urandom,
             ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 5)), $urandom,
             4'($urandom_range(1, 15)));
      end
      if ($urandom_range(0, 1) == 0) bcast(4'($urandom_range(0, 5)), $urandom);
      step();
    end
    idle(3);

    @(posedge clk); #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
